// File: rtl/if_prefetch_buffer.sv
`timescale 1ns/1ps
// Instruction-fetch prefetch buffer: issues one word fetch at a time over a
// req/gnt/rvalid handshake, queues returned {pc, instruction} pairs in a small
// in-order FIFO and presents the head to the IF/ID register, with hazard stall
// and branch flush/redirect.
module if_prefetch_buffer #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter logic [31:0] NOP      = 32'h13
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] pc_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        valid_out,
    output logic [31:0] ir_out,
    output logic [31:0] pc_out
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DROP} state_t;

    state_t          state_reg, state_next;
    logic            imem_req_reg, imem_req_next;
    logic [31:0]     imem_addr_reg, imem_addr_next;
    logic [31:0]     pc_fetch_reg, pc_fetch_next;
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [PTR_W:0]  count_reg;
    logic [31:0]     ir_mem [DEPTH];
    logic [31:0]     pc_mem [DEPTH];
    logic            push;
    logic            pop;

    assign imem_req  = imem_req_reg;
    assign imem_addr = imem_addr_reg;

    // Head is presented straight from stored entries; empty buffer shows a NOP at pc 0.
    assign valid_out = (count_reg != '0);
    assign ir_out    = valid_out ? ir_mem[rd_ptr_reg] : NOP;
    assign pc_out    = valid_out ? pc_mem[rd_ptr_reg] : 32'h0;
    assign pop       = valid_out && !stall && !flush;

    // Fetch FSM next-state: one request outstanding; a flush abandons or drains it.
    always_comb begin
        state_next     = state_reg;
        imem_req_next  = imem_req_reg;
        imem_addr_next = imem_addr_reg;
        pc_fetch_next  = pc_fetch_reg;
        push           = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (!flush && (count_reg < DEPTH_CNT)) begin
                    state_next     = S_REQ;
                    imem_req_next  = 1'b1;
                    imem_addr_next = pc_fetch_reg;
                end
            end
            S_REQ: begin
                if (flush) begin
                    state_next    = S_IDLE;
                    imem_req_next = 1'b0;
                end else if (imem_gnt) begin
                    state_next    = S_WAIT;
                    imem_req_next = 1'b0;
                    pc_fetch_next = pc_fetch_reg + 32'd4;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    state_next = S_IDLE;
                    push       = !flush;
                end else if (flush) begin
                    // Data still owed by memory; swallow it before fetching again.
                    state_next = S_DROP;
                end
            end
            S_DROP: begin
                if (imem_rvalid) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
        // A redirect always wins over the sequential fetch address.
        if (flush) begin
            pc_fetch_next = pc_addr;
        end
    end

    // Fetch FSM and request/address registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= S_IDLE;
            imem_req_reg  <= 1'b0;
            imem_addr_reg <= RESET_PC;
            pc_fetch_reg  <= RESET_PC;
        end else begin
            state_reg     <= state_next;
            imem_req_reg  <= imem_req_next;
            imem_addr_reg <= imem_addr_next;
            pc_fetch_reg  <= pc_fetch_next;
        end
    end

    // FIFO pointers and occupancy; flush empties the buffer outright.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (push && !pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (!push && pop) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

    // FIFO storage; the pc of an entry is the address its fetch was issued to.
    always_ff @(posedge clk) begin
        if (push) begin
            ir_mem[wr_ptr_reg] <= imem_rdata;
            pc_mem[wr_ptr_reg] <= imem_addr_reg;
        end
    end

endmodule

// File: tb/tb_if_prefetch_buffer.sv
`timescale 1ns/1ps
// Bench for if_prefetch_buffer: cycle table from reset, directed stall/flush/reset
// sequences, then randomized traffic against a program-order reference model.
module tb_if_prefetch_buffer;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam logic [31:0] NOP      = 32'h13;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] pc_addr = 32'h0;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        valid_out;
    logic [31:0] ir_out;
    logic [31:0] pc_out;

    if_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .NOP(NOP)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .pc_addr(pc_addr),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .valid_out(valid_out), .ir_out(ir_out), .pc_out(pc_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Instruction memory contents as a function of word address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {2'b00, a[31:2]} ^ 32'hC0DE_0000;
    endfunction

    // Memory responder state
    bit          mem_busy = 0;
    int          rv_cnt = 0;
    logic [31:0] mem_addr = 0;
    int          lat_lo = 1, lat_hi = 1, gnt_pct = 100;
    int          n_grants = 0;
    logic [31:0] last_gnt_addr = 0;

    // Reference model: program-order streams restarted by reset/redirect
    logic [31:0] m_fetch = RESET_PC;
    logic [31:0] m_deliver = RESET_PC;
    int          m_occ = 0;
    bit          live = 0;
    int          n_deliv = 0;

    // One clock: drive memory side, compare against model, advance to next negedge.
    task automatic tick();
        bit busy_start;
        bit do_pop;
        busy_start  = mem_busy;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        if (mem_busy) begin
            rv_cnt--;
            if (rv_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(mem_addr);
                mem_busy    = 0;
            end
        end
        if (imem_req && !flush && !busy_start && ($urandom_range(0, 99) < gnt_pct))
            imem_gnt = 1'b1;

        check("valid_out", valid_out, (m_occ != 0));
        if (!valid_out) begin
            check("empty_ir", ir_out, NOP);
            check("empty_pc", pc_out, 32'h0);
        end
        if (m_occ == DEPTH) check("req_when_full", imem_req, 1'b0);
        do_pop = (m_occ != 0) && !stall && !flush;
        if (do_pop) begin
            check("deliver_pc", pc_out, m_deliver);
            check("deliver_ir", ir_out, mem_word(m_deliver));
            $display("deliver pc=%h ir=%h", pc_out, ir_out);
            m_deliver = m_deliver + 32'd4;
            m_occ--;
            n_deliv++;
        end
        if (imem_gnt) begin
            check("fetch_addr", imem_addr, m_fetch);
            mem_busy      = 1;
            rv_cnt        = $urandom_range(lat_lo, lat_hi);
            mem_addr      = imem_addr;
            last_gnt_addr = imem_addr;
            n_grants++;
            live          = 1;
            m_fetch       = m_fetch + 32'd4;
        end
        if (imem_rvalid) begin
            if (live && !flush) m_occ++;
            live = 0;
        end
        if (flush) begin
            m_occ     = 0;
            live      = 0;
            m_fetch   = pc_addr;
            m_deliver = pc_addr;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_reset();
        m_occ     = 0;
        live      = 0;
        m_fetch   = RESET_PC;
        m_deliver = RESET_PC;
    endtask

    task automatic do_reset();
        rst = 1'b0; stall = 1'b0; flush = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic        stall;
        logic        flush;
        logic [31:0] pc_addr;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_ir;
        logic [31:0] e_pc;
    } vec_t;

    function automatic vec_t mk(input logic g, input logic r, input logic [31:0] d,
                                input logic s, input logic f, input logic [31:0] pa,
                                input logic er, input logic [31:0] ea, input logic ev,
                                input logic [31:0] ei, input logic [31:0] ep);
        vec_t v;
        v.gnt = g; v.rvalid = r; v.rdata = d; v.stall = s; v.flush = f; v.pc_addr = pa;
        v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_ir = ei; v.e_pc = ep;
        return v;
    endfunction

    vec_t vecs [16];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        bit ok;
        int g0;

        //          gnt rv rdata   st fl pc_addr   req addr      v  ir      pc
        vecs[0]  = mk(0, 0, 32'h0,  0, 0, 32'h0,   1, 32'h0,   0, NOP,    32'h0);
        vecs[1]  = mk(1, 0, 32'h0,  0, 0, 32'h0,   0, 32'h0,   0, NOP,    32'h0);
        vecs[2]  = mk(0, 1, 32'h0,  0, 0, 32'h0,   0, 32'h0,   1, 32'h0,  32'h0);
        vecs[3]  = mk(0, 0, 32'h0,  0, 0, 32'h0,   1, 32'h4,   0, NOP,    32'h0);
        vecs[4]  = mk(1, 0, 32'h0,  0, 0, 32'h0,   0, 32'h4,   0, NOP,    32'h0);
        vecs[5]  = mk(0, 1, 32'h1,  0, 0, 32'h0,   0, 32'h4,   1, 32'h1,  32'h4);
        vecs[6]  = mk(0, 0, 32'h0,  0, 0, 32'h0,   1, 32'h8,   0, NOP,    32'h0);
        vecs[7]  = mk(1, 0, 32'h0,  0, 0, 32'h0,   0, 32'h8,   0, NOP,    32'h0);
        vecs[8]  = mk(0, 1, 32'h2,  0, 0, 32'h0,   0, 32'h8,   1, 32'h2,  32'h8);
        vecs[9]  = mk(0, 0, 32'h0,  0, 0, 32'h0,   1, 32'hC,   0, NOP,    32'h0);
        vecs[10] = mk(0, 0, 32'h0,  0, 1, 32'h200, 0, 32'hC,   0, NOP,    32'h0);
        vecs[11] = mk(0, 0, 32'h0,  0, 0, 32'h0,   1, 32'h200, 0, NOP,    32'h0);
        vecs[12] = mk(1, 0, 32'h0,  0, 0, 32'h0,   0, 32'h200, 0, NOP,    32'h0);
        vecs[13] = mk(0, 1, 32'h80, 0, 0, 32'h0,   0, 32'h200, 1, 32'h80, 32'h200);
        vecs[14] = mk(0, 0, 32'h0,  1, 0, 32'h0,   1, 32'h204, 1, 32'h80, 32'h200);
        vecs[15] = mk(0, 0, 32'h0,  1, 1, 32'h300, 0, 32'h204, 0, NOP,    32'h0);

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_req", imem_req, 1'b0);
        check("rst_addr", imem_addr, RESET_PC);
        check("rst_valid", valid_out, 1'b0);
        check("rst_ir", ir_out, NOP);
        check("rst_pc", pc_out, 32'h0);
        $display("reset state: req=%b addr=%h valid=%b ir=%h pc=%h", imem_req, imem_addr, valid_out, ir_out, pc_out);
        rst = 1'b1;

        // Cycle table from reset release
        for (int k = 0; k < 16; k++) begin
            imem_gnt = vecs[k].gnt; imem_rvalid = vecs[k].rvalid; imem_rdata = vecs[k].rdata;
            stall = vecs[k].stall; flush = vecs[k].flush; pc_addr = vecs[k].pc_addr;
            @(posedge clk);
            #1;
            check("tbl_req", imem_req, vecs[k].e_req);
            check("tbl_addr", imem_addr, vecs[k].e_addr);
            check("tbl_valid", valid_out, vecs[k].e_valid);
            check("tbl_ir", ir_out, vecs[k].e_ir);
            check("tbl_pc", pc_out, vecs[k].e_pc);
            $display("vec %0d: req=%b addr=%h valid=%b ir=%h pc=%h", k + 1, imem_req, imem_addr, valid_out, ir_out, pc_out);
            @(negedge clk);
        end
        imem_gnt = 0; imem_rvalid = 0; stall = 0; flush = 0;

        // Stall held: buffer fills to DEPTH, head frozen at pc 0, no further requests
        do_reset();
        stall = 1'b1;
        n_grants = 0;
        for (int i = 0; i < 20; i++) tick();
        check("stall_grants", n_grants, 4);
        check("stall_valid", valid_out, 1'b1);
        check("stall_pc", pc_out, 32'h0);
        check("stall_ir", ir_out, mem_word(32'h0));
        check("stall_req", imem_req, 1'b0);
        $display("stall: grants=%0d head pc=%h", n_grants, pc_out);
        stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("drain_valid", valid_out, 1'b1);
            check("drain_pc", pc_out, 32'(4 * i));
            tick();
        end
        for (int i = 0; i < 10; i++) tick();

        // Flush while waiting for data; data returns three cycles after the flush
        lat_lo = 4; lat_hi = 4;
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            if (mem_busy && rv_cnt == 4) begin ok = 1; break; end
            tick();
        end
        check("t3_reach_wait", ok, 1'b1);
        flush = 1'b1; pc_addr = 32'h100;
        tick();
        flush = 1'b0;
        check("t3_valid_after_flush", valid_out, 1'b0);
        g0 = n_grants; ok = 0;
        for (int i = 0; i < 30; i++) begin
            if (n_grants != g0) begin ok = 1; break; end
            tick();
        end
        check("t3_regrant", ok, 1'b1);
        check("t3_addr", last_gnt_addr, 32'h100);
        $display("flush in wait: next fetch=%h", last_gnt_addr);
        for (int i = 0; i < 8; i++) tick();

        // Flush coinciding with rvalid
        lat_lo = 2; lat_hi = 2;
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            if (mem_busy && rv_cnt == 1) begin ok = 1; break; end
            tick();
        end
        check("t4_reach_rvalid", ok, 1'b1);
        flush = 1'b1; pc_addr = 32'h200;
        tick();
        flush = 1'b0;
        check("t4_valid_after_flush", valid_out, 1'b0);
        g0 = n_grants; ok = 0;
        for (int i = 0; i < 30; i++) begin
            if (n_grants != g0) begin ok = 1; break; end
            tick();
        end
        check("t4_regrant", ok, 1'b1);
        check("t4_addr", last_gnt_addr, 32'h200);
        $display("flush with rvalid: next fetch=%h", last_gnt_addr);
        for (int i = 0; i < 8; i++) tick();

        // Asynchronous reset in the middle of a wait; stale rvalid must be ignored
        lat_lo = 5; lat_hi = 5;
        stall = 1'b1;
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            if (mem_busy && m_occ > 0) begin ok = 1; break; end
            tick();
        end
        check("t6_reach_wait", ok, 1'b1);
        #2;
        rst = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
        #1;
        check("t6_req", imem_req, 1'b0);
        check("t6_addr", imem_addr, RESET_PC);
        check("t6_valid", valid_out, 1'b0);
        check("t6_ir", ir_out, NOP);
        check("t6_pc", pc_out, 32'h0);
        $display("async reset: req=%b valid=%b ir=%h", imem_req, valid_out, ir_out);
        @(negedge clk);
        rst = 1'b1;
        stall = 1'b0;
        model_reset();
        g0 = n_grants; ok = 0;
        for (int i = 0; i < 30; i++) begin
            if (n_grants != g0) begin ok = 1; break; end
            tick();
        end
        check("t6_regrant", ok, 1'b1);
        check("t6_addr_restart", last_gnt_addr, RESET_PC);
        for (int i = 0; i < 10; i++) tick();

        // Randomized traffic
        lat_lo = 1; lat_hi = 3; gnt_pct = 60;
        n_deliv = 0;
        for (int i = 0; i < 800; i++) begin
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 19) == 0);
            if (flush) pc_addr = $urandom & 32'hFFFF_FFFC;
            tick();
        end
        stall = 0; flush = 0;
        check("random_progress", (n_deliv > 20), 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
